// File: rtl/cond_alu_seq.sv
// rtl/cond_alu_seq.sv - sequential ALU stage producing a result and NZCV flags for the flag register
//
// Purpose: accepts one operation per start/done handshake. Single-cycle ops
// write result/flags on the accept edge. MUL is an iterative shift-add that
// writes result/flags after WIDTH further edges.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request, accepted only while busy=0
//   op         opcode, sampled at accept
//   a, b       operands, sampled at accept
//   flags_in   current NZCV ([3]=N,[2]=Z,[1]=C,[0]=V), sampled at accept
//   busy       high while an operation is in flight
//   done       one-cycle completion pulse
//   result     registered result
//   flags_out  registered NZCV, same bit order as flags_in
//   flags_we   equals done; write enable for the flag register

module cond_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       flags_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags_out,
    output logic             flags_we
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q,  state_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [3:0]             flags_q,  flags_d;
    logic [CW-1:0]          cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]     acc_q,    acc_d;
    logic [2*WIDTH-1:0]     a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]       b_sh_q,   b_sh_d;

    // Shared adder for ADD/SUB/ADC/CMP: a + addend + carry_in
    logic [WIDTH-1:0]       addend;
    logic                   add_cin;
    logic [WIDTH:0]         sum_ext;
    logic [WIDTH-1:0]       sum;
    logic                   add_c;
    logic                   add_v;
    logic [WIDTH-1:0]       logic_res;
    logic [2*WIDTH-1:0]     acc_nxt;

    always_comb begin
        addend  = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB, OP_CMP: begin
                addend  = ~b;
                add_cin = 1'b1;
            end
            OP_ADC:  add_cin = flags_in[1];
            default: ;
        endcase
        sum_ext = (WIDTH+1)'(a) + (WIDTH+1)'(addend) + (WIDTH+1)'(add_cin);
        sum     = sum_ext[WIDTH-1:0];
        add_c   = sum_ext[WIDTH];
        // Signed overflow: same-sign inputs to the adder, differently-signed sum
        add_v   = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        case (op)
            OP_AND:  logic_res = a & b;
            OP_OR:   logic_res = a | b;
            default: logic_res = a ^ b;
        endcase

        acc_nxt = acc_q + (b_sh_q[0] ? a_sh_q : '0);
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MUL: begin
                            state_d = S_MUL;
                            cnt_d   = '0;
                            acc_d   = '0;
                            a_sh_d  = {{WIDTH{1'b0}}, a};
                            b_sh_d  = b;
                        end
                        OP_ADD, OP_SUB, OP_ADC: begin
                            state_d  = S_DONE;
                            result_d = sum;
                            flags_d  = {sum[WIDTH-1], sum == '0, add_c, add_v};
                        end
                        OP_CMP: begin
                            state_d = S_DONE;
                            flags_d = {sum[WIDTH-1], sum == '0, add_c, add_v};
                        end
                        default: begin
                            state_d  = S_DONE;
                            result_d = logic_res;
                            flags_d  = {logic_res[WIDTH-1], logic_res == '0,
                                        flags_in[1], flags_in[0]};
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_d  = acc_nxt;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    result_d = acc_nxt[WIDTH-1:0];
                    flags_d  = {acc_nxt[WIDTH-1], acc_nxt[WIDTH-1:0] == '0,
                                |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign flags_we  = done;
    assign result    = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_cond_alu_seq.sv
// tb/tb_cond_alu_seq.sv - directed self-checking bench for cond_alu_seq

module tb_cond_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   flags_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags_out;
    logic         flags_we;

    int total = 0;
    int bad   = 0;

    cond_alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flags_in  (flags_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags_out (flags_out),
        .flags_we  (flags_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request before edge k, then scramble inputs after edge k
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] f);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        flags_in = f;
        @(posedge clk);
        #1;
        start    = 1'b0;
        op       = 3'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        flags_in = 4'($urandom);
    endtask

    // Walk cycles k+1..k+lat: busy high throughout, done/flags_we only in the last.
    // inj>0 pulses an extra start in cycle k+inj, which must be ignored.
    task automatic run(input string tag, input int lat, input int inj,
                       input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        int extra;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (c == inj) begin
                op = 3'b000;
                a  = 8'h01;
                b  = 8'h01;
            end
            chk({tag, "_busy"}, busy, 1'b1);
            chk({tag, "_done"}, done, (c == lat));
            chk({tag, "_we"}, flags_we, (c == lat));
        end
        start = 1'b0;
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_flags"}, flags_out, exp_flags);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) extra++;
            if (c == 0) chk({tag, "_idle"}, busy, 1'b0);
        end
        chk({tag, "_no_extra_done"}, extra, 0);
        chk({tag, "_hold_result"}, result, exp_res);
        chk({tag, "_hold_flags"}, flags_out, exp_flags);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        a        = '0;
        b        = '0;
        flags_in = '0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_flags", flags_out, 4'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        issue(3'b000, 8'h7F, 8'h01, 4'b0000);
        run("add", 1, 0, 8'h80, 4'b1001);

        issue(3'b001, 8'h05, 8'h05, 4'b0000);
        run("sub", 1, 0, 8'h00, 4'b0110);

        issue(3'b111, 8'h03, 8'h05, 4'b0000);
        run("cmp", 1, 0, 8'h00, 4'b1000);

        issue(3'b010, 8'hFF, 8'h00, 4'b0010);
        run("adc", 1, 0, 8'h00, 4'b0110);

        issue(3'b011, 8'hF0, 8'h0F, 4'b0011);
        run("and", 1, 0, 8'h00, 4'b0111);

        issue(3'b101, 8'hA5, 8'h0F, 4'b0001);
        run("xor", 1, 0, 8'hAA, 4'b1001);

        issue(3'b110, 8'h10, 8'h20, 4'b0000);
        run("mul_ovf", 9, 4, 8'h00, 4'b0110);

        issue(3'b110, 8'h0D, 8'h0B, 4'b0111);
        run("mul", 9, 0, 8'h8F, 4'b1000);

        issue(3'b100, 8'h80, 8'h01, 4'b0011);
        run("or", 1, 0, 8'h81, 4'b1011);

        // Reset during MUL: outputs clear at once and the MUL never completes
        issue(3'b110, 8'h0D, 8'h0B, 4'b0000);
        for (int c = 1; c < 4; c++) @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_result", result, 8'h00);
        chk("mrst_flags", flags_out, 4'h0);
        begin
            int seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (done) seen++;
            end
            reset = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (done) seen++;
            end
            chk("mrst_no_done", seen, 0);
        end

        issue(3'b000, 8'h01, 8'h02, 4'b0000);
        run("add_after_rst", 1, 0, 8'h03, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
